// File: rtl/sseg_scan_ctrl.sv
// rtl/sseg_scan_ctrl.sv - multiplexed 7-segment scan controller with frame-synchronous display update
// Time-multiplexes NUM_DIGITS nibbles onto one shared decoder, with dead time between digits.
module sseg_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    scan_en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    lz_blank,
  output logic [3:0]              hex,
  output logic                    dp,
  output logic                    dec_en,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int CNT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int IW      = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] DRIVE_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [IW-1:0]   idx, idx_nxt;
  logic            frame_end;

  logic [4*NUM_DIGITS-1:0] stage_val, disp_val;
  logic [NUM_DIGITS-1:0]   stage_dp, disp_dp;
  logic                    pending;
  logic                    copy_now;

  logic [NUM_DIGITS-1:0]   lz_zero;
  logic [NUM_DIGITS-1:0]   sel_d;
  logic [3:0]              nib_d;
  logic                    dp_d;
  logic                    en_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    idx_nxt   = idx;
    frame_end = 1'b0;
    if (!scan_en) begin
      state_nxt = ST_BLANK;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nxt = ST_DRIVE;
            cnt_nxt   = '0;
          end
        end
        ST_DRIVE: begin
          if (cnt == DRIVE_LAST) begin
            state_nxt = ST_BLANK;
            cnt_nxt   = '0;
            if (idx == IDX_LAST) begin
              idx_nxt   = '0;
              frame_end = 1'b1;
            end else begin
              idx_nxt = idx + IW'(1);
            end
          end
        end
        default: begin
          state_nxt = ST_BLANK;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  // Display only changes between frames (or while idle) so a frame never mixes old and new data.
  assign copy_now = (frame_end || !scan_en) && (pending || load);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_val <= '0;
      stage_dp  <= '0;
      disp_val  <= '0;
      disp_dp   <= '0;
      pending   <= 1'b0;
    end else begin
      if (load) begin
        stage_val <= value;
        stage_dp  <= dp_mask;
      end
      if (copy_now) begin
        disp_val <= load ? value : stage_val;
        disp_dp  <= load ? dp_mask : stage_dp;
        pending  <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // lz_zero[i] is set when nibbles i..NUM_DIGITS-1 are all zero.
  always_comb begin
    lz_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (i == NUM_DIGITS - 1) begin
        lz_zero[i] = (disp_val[i*4 +: 4] == 4'h0);
      end else begin
        lz_zero[i] = lz_zero[i+1] && (disp_val[i*4 +: 4] == 4'h0);
      end
    end
  end

  always_comb begin
    sel_d = '0;
    nib_d = 4'h0;
    dp_d  = 1'b0;
    en_d  = 1'b0;
    if (state == ST_DRIVE) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx == IW'(i)) begin
          sel_d[i] = 1'b1;
          nib_d    = disp_val[i*4 +: 4];
          dp_d     = disp_dp[i];
          en_d     = !(lz_blank && (i != 0) && lz_zero[i]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex        <= 4'h0;
      dp         <= 1'b0;
      dec_en     <= 1'b0;
      digit_sel  <= '0;
      frame_done <= 1'b0;
    end else if (!scan_en) begin
      hex        <= 4'h0;
      dp         <= 1'b0;
      dec_en     <= 1'b0;
      digit_sel  <= '0;
      frame_done <= 1'b0;
    end else begin
      hex        <= nib_d;
      dp         <= dp_d;
      dec_en     <= en_d;
      digit_sel  <= sel_d;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb/tb_sseg_scan_ctrl.sv - directed bench for sseg_scan_ctrl (4 digits, 4 drive / 2 blank clocks)
module tb_sseg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scan_en;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        lz_blank;
  logic [3:0]  hex;
  logic        dp;
  logic        dec_en;
  logic [3:0]  digit_sel;
  logic        frame_done;

  int passed = 0;
  int total  = 0;

  sseg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .DIGIT_CYCLES(4),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scan_en   (scan_en),
    .load      (load),
    .value     (value),
    .dp_mask   (dp_mask),
    .lz_blank  (lz_blank),
    .hex       (hex),
    .dp        (dp),
    .dec_en    (dec_en),
    .digit_sel (digit_sel),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] v;
    logic [3:0]  dpm;
    logic        lz;
    logic [3:0]  en;
    int          ld_t;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input bit ok, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic wait_fd();
    int n = 0;
    while (frame_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done timeout", frame_done === 1'b1, {15'd0, frame_done}, 16'd1);
  endtask

  // {digit_sel, hex, dp, dec_en, frame_done} packed for reporting
  task automatic chk_out(input string name, input logic [3:0] esel, input logic [3:0] ehex,
                         input logic edp, input logic een, input logic efd, input bit blank_only);
    logic [15:0] act, exp;
    bit ok;
    act = {5'd0, digit_sel, hex, dp, dec_en, frame_done};
    exp = {5'd0, esel, ehex, edp, een, efd};
    if (blank_only) ok = (digit_sel === 4'b0) && (dec_en === 1'b0) && (frame_done === efd);
    else            ok = (act === exp);
    chk(name, ok, act, exp);
  endtask

  // Checks cycles t=1..last_t after a frame_done cycle; optionally loads nv/ndp at cycle ld_t.
  task automatic check_frame(input logic [15:0] v, input logic [3:0] dpm, input logic [3:0] en,
                             input int last_t, input int ld_t, input logic [15:0] nv, input logic [3:0] ndp);
    int d, ph;
    for (int t = 1; t <= last_t; t++) begin
      @(negedge clk);
      load = 1'b0;
      d  = (t - 1) / 6;
      ph = (t - 1) % 6;
      if (ph < 2) chk_out($sformatf("blank t=%0d", t), 4'b0, 4'h0, 1'b0, 1'b0, (t == 24), 1'b1);
      else        chk_out($sformatf("digit%0d t=%0d", d, t), 4'b1 << d, v[d*4 +: 4], dpm[d], en[d], (t == 24), 1'b0);
      if (t == ld_t) begin
        value   = nv;
        dp_mask = ndp;
        load    = 1'b1;
      end
    end
  endtask

  initial begin
    vec_t prev;
    vecs[0] = '{v: 16'h1234, dpm: 4'b0010, lz: 1'b0, en: 4'b1111, ld_t: 1};
    vecs[1] = '{v: 16'h0050, dpm: 4'b0000, lz: 1'b1, en: 4'b0011, ld_t: 10};
    vecs[2] = '{v: 16'h0000, dpm: 4'b0001, lz: 1'b1, en: 4'b0001, ld_t: 23};
    vecs[3] = '{v: 16'hAAAA, dpm: 4'b1111, lz: 1'b0, en: 4'b1111, ld_t: 10};
    vecs[4] = '{v: 16'h0A00, dpm: 4'b0100, lz: 1'b1, en: 4'b0111, ld_t: 20};
    vecs[5] = '{v: 16'hF00F, dpm: 4'b1001, lz: 1'b1, en: 4'b1111, ld_t: 5};
    vecs[6] = '{v: 16'h1234, dpm: 4'b0000, lz: 1'b1, en: 4'b1111, ld_t: 15};

    rst_n    = 1'b0;
    scan_en  = 1'b1;
    load     = 1'b0;
    value    = 16'h0;
    dp_mask  = 4'h0;
    lz_blank = 1'b0;
    repeat (3) @(negedge clk);
    chk_out("reset state", 4'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    wait_fd();
    prev = '{v: 16'h0000, dpm: 4'b0000, lz: 1'b0, en: 4'b1111, ld_t: 0};
    for (int i = 0; i < 7; i++) begin
      lz_blank = prev.lz;
      check_frame(prev.v, prev.dpm, prev.en, 24, vecs[i].ld_t, vecs[i].v, vecs[i].dpm);
      prev = vecs[i];
    end
    lz_blank = prev.lz;

    // Two loads within one frame: only the later one reaches the display.
    value = 16'h5555; dp_mask = 4'b1111; load = 1'b1;
    check_frame(prev.v, prev.dpm, prev.en, 24, 12, 16'h6666, 4'b0101);
    lz_blank = 1'b0;

    // Drop scan_en during digit 2, load while idle, then restart.
    check_frame(16'h6666, 4'b0101, 4'b1111, 16, 0, 16'h0, 4'h0);
    scan_en = 1'b0;
    value = 16'h9876; dp_mask = 4'b1000; load = 1'b1;
    @(negedge clk); load = 1'b0;
    chk_out("scan_en off edge", 4'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_out("scan_en off hold", 4'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    scan_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk_out($sformatf("restart blank %0d", k), 4'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_out($sformatf("restart digit0 %0d", k), 4'b0001, 4'h6, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    @(negedge clk);
    chk_out("restart gap", 4'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_fd();
    check_frame(16'h9876, 4'b1000, 4'b1111, 24, 0, 16'h0, 4'h0);

    // Asynchronous reset during digit 0 drive with a load pending.
    value = 16'h7777; dp_mask = 4'b1111; load = 1'b1;
    @(negedge clk); load = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_out("async reset", 4'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk_out($sformatf("post-reset blank %0d", k), 4'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    @(negedge clk);
    chk_out("post-reset digit0", 4'b0001, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_fd();
    check_frame(16'h0000, 4'b0000, 4'b1111, 24, 0, 16'h0, 4'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
